d_flip_flop: RTL and testbench
==============================

// Module: d_flip_flop
//
// PURPOSE
//   Edge-triggered D-type storage register: samples data input d on each rising
//   clock edge and presents it on q one cycle later.
//   Asynchronous active-low reset forces q to a known value.
//   Basic sequential leaf cell for pipelines, synchronizer stages and state
//   registers throughout the behavioural library.
//
// PARAMETERS
//   WIDTH      1    data width in bits of d and q (legal range >= 1)
//   RESET_VAL  0    value loaded into q while reset is asserted (WIDTH bits, zero-extended)
//
// PORTS
//   clock  input   1      single clock; all state changes on rising edge only
//   reset  input   1      asynchronous, active-low reset (0 = reset asserted)
//   d      input   WIDTH  data to be captured
//   q      output  WIDTH  registered data; driven directly from storage (no comb path from d)
//
// BEHAVIOUR
//   - One clock domain, one asynchronous reset. Polarity and synchronicity are fixed.
//   - Reset assertion (reset falls to 0):
//     - q = RESET_VAL immediately, without waiting for a clock edge.
//     - q holds RESET_VAL for as long as reset = 0, regardless of clock or d activity.
//   - Reset release (reset rises to 1):
//     - q keeps RESET_VAL until the first rising clock edge with reset = 1.
//     - That edge captures d; there is no extra dead cycle.
//   - Normal operation (reset = 1):
//     - At each posedge clock, q <= d, with d sampled at that edge.
//     - Between edges, q is stable; d glitches have no effect.
//   - Latency: exactly 1 clock; q after edge N equals d at edge N.
//   - No enable: every rising edge with reset high loads d, even when d is unchanged.
//   - Simultaneous events:
//     - reset low coincident with posedge clock: reset wins, q = RESET_VAL.
//     - reset rising on the same instant as posedge clock: treated as still in
//       reset, so q stays RESET_VAL and capture starts on the following edge.
//   - Width rules:
//     - All WIDTH bits are captured in parallel; no arithmetic.
//     - RESET_VAL wider than WIDTH is truncated to the LSBs.
//   - Falling clock edges are ignored.
//   - X/Z on d is propagated to q unchanged; no X-masking.
//   - Power-up with no reset: q is unspecified until the first capture or reset.
//
// TESTING
//   Clock: 20 ns period (toggles every 10 ns). WIDTH = 1, RESET_VAL = 0 unless stated.
//   1. Reset assert:
//      reset = 0 with q previously 1, mid-cycle with no clock edge
//      -> q = 0 within the same timestep.
//   2. Reset hold:
//      reset = 0 for 3 clock edges while d toggles 1/0/1
//      -> q stays 0 throughout.
//   3. Capture after release:
//      release reset to 1 at t = 5 ns; d = 1 at the edge at t = 10 ns
//      -> q = 1 after 10 ns; d = 0 at the edge at t = 30 ns -> q = 0 after 30 ns.
//   4. Random stream:
//      d driven with random values, changing midway between rising edges, for 50 edges
//      -> after every edge, q equals d sampled at that edge; q is stable between edges.
//   5. Coincident reset:
//      reset falls at the same time as a rising edge with d = 1
//      -> q = 0. Reset rises at the same time as an edge
//      -> q stays 0 until the next edge.
//   6. Parameter sweep:
//      WIDTH = 8, RESET_VAL = 8'hA5, reset pulse low
//      -> q = 8'hA5; then d = 8'h3C at the next edge -> q = 8'h3C.

Source files
------------

// File: rtl/d_flip_flop.sv
// Edge-triggered D register with asynchronous active-low reset.
// q is driven straight from storage; there is no combinational path from d.
module d_flip_flop #(
  parameter int unsigned WIDTH     = 1,
  parameter logic [63:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // A wide reset value keeps its LSBs; a narrow one is zero-extended.
  localparam logic [WIDTH-1:0] LP_RESET = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= LP_RESET;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop: directed reset/capture sequences, a vector table on
// 8-bit and 4-bit instances, and a random stream checked against a sample queue.
module tb_d_flip_flop;

  logic       clock;
  logic       reset;
  logic       d1;
  logic       q1;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [3:0] d4;
  logic [3:0] q4;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       rst_n;
    logic [7:0] d;
    logic [7:0] exp8;
    logic [3:0] exp4;
  } vec_t;

  vec_t vecs[8];

  d_flip_flop u_dut1 (
    .clock (clock),
    .reset (reset),
    .d     (d1),
    .q     (q1)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VAL(64'hA5)) u_dut8 (
    .clock (clock),
    .reset (reset),
    .d     (d8),
    .q     (q8)
  );

  // RESET_VAL wider than the data path: only the low nibble (4'h5) survives.
  d_flip_flop #(.WIDTH(4), .RESET_VAL(64'hA5)) u_dut4 (
    .clock (clock),
    .reset (reset),
    .d     (d4),
    .q     (q4)
  );

  // Clock / reset block
  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] exp;
    logic [7:0] last_exp;

    vecs[0] = '{1'b0, 8'h77, 8'hA5, 4'h5};
    vecs[1] = '{1'b1, 8'h3C, 8'h3C, 4'hC};
    vecs[2] = '{1'b1, 8'hFF, 8'hFF, 4'hF};
    vecs[3] = '{1'b1, 8'hFF, 8'hFF, 4'hF};
    vecs[4] = '{1'b1, 8'h00, 8'h00, 4'h0};
    vecs[5] = '{1'b0, 8'h5A, 8'hA5, 4'h5};
    vecs[6] = '{1'b1, 8'h81, 8'h81, 4'h1};
    vecs[7] = '{1'b1, 8'h42, 8'h42, 4'h2};

    reset = 1'b1;
    d1 = 1'b0;
    d8 = 8'h00;
    d4 = 4'h0;

    // Reset values on all instances, no clock edge involved.
    #1 reset = 1'b0;
    #1;
    check1("rst_q1", q1, 1'b0);
    check8("rst_q8", q8, 8'hA5);
    check8("rst_q4", {4'h0, q4}, 8'h05);

    // Release at t=5, capture at t=10 and t=30.
    #3 reset = 1'b1;
    d1 = 1'b1;
    @(posedge clock); #1;
    check1("cap_t10", q1, 1'b1);
    #9 d1 = 1'b0;
    @(posedge clock); #1;
    check1("cap_t30", q1, 1'b0);

    // Mid-cycle reset assertion with q previously 1.
    @(negedge clock) d1 = 1'b1;
    @(posedge clock); #1;
    check1("pre_async", q1, 1'b1);
    #4 reset = 1'b0;
    #1;
    check1("async_assert", q1, 1'b0);
    check8("async_assert8", q8, 8'hA5);

    // Held in reset across three edges while d toggles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock) d1 = (i != 1);
      @(posedge clock); #1;
      check1("reset_hold", q1, 1'b0);
    end

    @(negedge clock) begin
      reset = 1'b1;
      d1 = 1'b1;
    end
    @(posedge clock); #1;
    check1("release_cap", q1, 1'b1);

    // Reset events landing exactly on a rising edge; the nonblocking drive
    // makes the flop see the pre-edge reset level at that edge.
    @(posedge clock) reset <= 1'b0;
    #1;
    check1("coinc_fall", q1, 1'b0);
    @(posedge clock) reset <= 1'b1;
    #1;
    check1("coinc_rise", q1, 1'b0);
    @(posedge clock); #1;
    check1("coinc_next", q1, 1'b1);

    // Vector table on the wide instances, including a reset pulse then 8'h3C.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock) begin
        reset = vecs[i].rst_n;
        d8 = vecs[i].d;
        d4 = vecs[i].d[3:0];
      end
      @(posedge clock); #1;
      check8("vec_q8", q8, vecs[i].exp8);
      check8("vec_q4", {4'h0, q4}, {4'h0, vecs[i].exp4});
    end
    last_exp = 8'h42;

    // Random stream: each edge must present exactly the value sampled there.
    for (int i = 0; i < 50; i++) begin
      @(negedge clock) begin
        v = 8'($urandom_range(0, 255));
        d8 = v;
        d4 = v[3:0];
        d1 = v[0];
        exp_q.push_back(v);
      end
      #5;
      check8("stable_q8", q8, last_exp);
      @(posedge clock); #1;
      exp = exp_q.pop_front();
      check8("rand_q8", q8, exp);
      check8("rand_q4", {4'h0, q4}, exp % 16);
      check1("rand_q1", q1, exp[0]);
      last_exp = exp;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
